regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//   Shares one register-file read port (a DATA_W-wide bank of 32:1 bit-muxes) among NUM_REQ requesters.
//   Round-robin arbitration drives the mux select and captures the mux output into a registered return.
//   Adds a one-cycle-latency valid/ID tag to the returned data.
//   Sits between the datapath stages that issue register reads and the register file read mux.
// PARAMETERS
//   NUM_REQ   4    number of requesters (>=2); ID_W = $clog2(NUM_REQ) (localparam)
//   ADDR_W    5    register address width = mux select width
//   DATA_W    32   register data width
// PORTS
//   clk          in   1               rising-edge clock; single clock domain
//   reset        in   1               synchronous, active-high reset
//   req          in   NUM_REQ         read request, one bit per requester
//   req_addr     in   NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
//   port_busy    in   1               read port unavailable this cycle; blocks all grants
//   gnt          out  NUM_REQ         one-hot grant, combinational, same cycle as arbitration
//   mux_sel      out  ADDR_W          select to read mux = granted requester's address, else 0
//   mux_data     in   DATA_W          read mux output, valid in the same cycle as mux_sel
//   rdata        out  DATA_W          registered read data
//   rdata_valid  out  1               rdata/rdata_id valid; one-cycle pulse per grant
//   rdata_id     out  ID_W            index of the requester that owns rdata
// BEHAVIOUR
//   State: priority pointer ptr[ID_W-1:0]; output registers rdata, rdata_valid, rdata_id.
//   Arbitration (combinational, cycle T):
//   - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod NUM_REQ.
//   - gnt = onehot(winner). gnt = 0 if reset=1, port_busy=1, or req=0.
//   - mux_sel = req_addr slice of winner while gnt!=0; otherwise 0.
//   Return (registered at end of cycle T):
//   - If gnt!=0: rdata<=mux_data, rdata_id<=winner, rdata_valid<=1.
//   - Otherwise rdata_valid<=0; rdata and rdata_id hold.
//   - Latency: data appears exactly 1 cycle after the grant.
//   - Back-to-back grants give continuous rdata_valid, one result per cycle.
//   Pointer:
//   - On grant to i, ptr <= (i+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
//   - No grant: ptr holds.
//   - Non-power-of-2 NUM_REQ: ptr never takes values >= NUM_REQ.
//   Handshake:
//   - Requester holds req and req_addr stable until it sees gnt.
//   - A request is consumed in its grant cycle; holding req after gnt issues a new read.
//   - Dropping req before grant withdraws the request with no side effect.
//   Fairness: with port_busy=0, a held request is granted within NUM_REQ cycles (at most NUM_REQ-1 others first).
//   Addresses are not interpreted; register 0 and all others are treated identically.
//   Reset (sync):
//   - ptr=0, rdata=0, rdata_id=0, rdata_valid=0; gnt=0 and mux_sel=0 while reset=1.
//   - Reset mid-operation: a grant in the reset cycle is suppressed, no return issued; requesters must re-request.
//   Simultaneous port_busy and reset: reset wins; both give gnt=0.
// TESTING
//   1 Reset: reset=1 two cycles with req=4'b1111.
//     -> gnt=0, rdata_valid=0, rdata=0.
//     -> First cycle after reset: gnt=4'b0001, mux_sel=req_addr[0].
//   2 Single requester: req=4'b0100, addr2=17, mux model returns 32'hA5A5_0011 for sel 17.
//     -> gnt=4'b0100, mux_sel=17 in cycle T.
//     -> T+1: rdata_valid=1, rdata=32'hA5A5_0011, rdata_id=2.
//   3 Round robin: req=4'b1111 held 8 cycles, distinct addrs.
//     -> gnt 0001,0010,0100,1000,0001,...
//     -> rdata_valid=1 each cycle from T+1; ids 0,1,2,3,0,...; data matches each address.
//   4 Wrap/skip: grant to 2 (ptr=3), then req=4'b0011.
//     -> gnt 0001 then 0010; ptr 1 then 2.
//   5 Busy: req=4'b0010, port_busy=1 for 3 cycles.
//     -> gnt=0, rdata_valid=0, ptr unchanged.
//     -> port_busy=0: gnt=4'b0010 that cycle, valid next cycle with id=1.
//   6 Reset mid-op: req=4'b0010 with reset=1 in cycle T.
//     -> gnt=0 in T; rdata_valid=0 at T+1; after release gnt=4'b0010, ptr starts at 0.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing one register-file read port
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic                      port_busy,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         mux_sel,
    input  logic [DATA_W-1:0]         mux_data,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rdata_valid,
    output logic [ID_W-1:0]           rdata_id
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            grant_en;
    logic [ID_W-1:0] ptr_next;

    // Scan from ptr upward, wrapping at NUM_REQ so non-power-of-2 counts never index past the last requester.
    always_comb begin
        logic [ID_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant_en = found && !reset && !port_busy;

    always_comb begin
        gnt     = '0;
        mux_sel = '0;
        if (grant_en) begin
            gnt     = NUM_REQ'(1) << winner;
            mux_sel = req_addr[int'(winner)*ADDR_W +: ADDR_W];
        end
    end

    assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            rdata       <= '0;
            rdata_id    <= '0;
            rdata_valid <= 1'b0;
        end else if (grant_en) begin
            ptr         <= ptr_next;
            rdata       <= mux_data;
            rdata_id    <= winner;
            rdata_valid <= 1'b1;
        end else begin
            rdata_valid <= 1'b0;
        end
    end

    a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt));
    a_gnt_has_req : assert property (@(posedge clk) (gnt & ~req) == '0);
    a_ptr_range : assert property (@(posedge clk) disable iff (reset) int'(ptr) < NUM_REQ);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - directed scoreboard bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic        port_busy;
    logic [3:0]  gnt;
    logic [4:0]  mux_sel;
    logic [31:0] mux_data;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [1:0]  rdata_id;

    int checks = 0;
    int passes = 0;
    int pushed = 0;
    int popped = 0;
    logic prev_grant = 1'b0;
    logic done = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  id;
    } ret_t;
    ret_t exp_q[$];

    regfile_read_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .port_busy(port_busy), .gnt(gnt), .mux_sel(mux_sel), .mux_data(mux_data),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_id(rdata_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mux_model(input logic [4:0] a);
        return {16'hA5A5, 11'd0, a};
    endfunction

    assign mux_data = mux_model(mux_sel);

    function automatic logic [1:0] onehot_id(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // One arbitration cycle: apply inputs, check combinational outputs and the return from the previous cycle.
    task automatic step(input string name, input logic [3:0] r, input logic b, input logic rs,
                        input logic [3:0] eg, input logic [4:0] es);
        @(posedge clk);
        #1;
        req = r; port_busy = b; reset = rs;
        #1;
        check({name, " gnt"}, 32'(gnt), 32'(eg));
        check({name, " mux_sel"}, 32'(mux_sel), 32'(es));
        check({name, " rdata_valid"}, 32'(rdata_valid), 32'(prev_grant));
        if (eg != 4'b0000) begin
            exp_q.push_back('{data: mux_model(es), id: onehot_id(eg)});
            pushed++;
        end
        prev_grant = (eg != 4'b0000);
    endtask

    initial begin : monitor
        ret_t e;
        while (!done) begin
            @(negedge clk);
            if (rdata_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected return", 32'(rdata_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    check("ret data", rdata, e.data);
                    check("ret id", 32'(rdata_id), 32'(e.id));
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; req = 4'b1111; port_busy = 1'b0;
        req_addr = {5'd0, 5'd17, 5'd9, 5'd3};

        step("rst0", 4'b1111, 1'b0, 1'b1, 4'b0000, 5'd0);
        step("rst1", 4'b1111, 1'b0, 1'b1, 4'b0000, 5'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst rdata_id", 32'(rdata_id), 32'd0);
        step("post_rst", 4'b1111, 1'b0, 1'b0, 4'b0001, 5'd3);

        step("single", 4'b0100, 1'b0, 1'b0, 4'b0100, 5'd17);
        step("idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 5'd0);

        step("rr_pre", 4'b1000, 1'b0, 1'b0, 4'b1000, 5'd0);
        for (int n = 0; n < 2; n++) begin
            step("rr0", 4'b1111, 1'b0, 1'b0, 4'b0001, 5'd3);
            step("rr1", 4'b1111, 1'b0, 1'b0, 4'b0010, 5'd9);
            step("rr2", 4'b1111, 1'b0, 1'b0, 4'b0100, 5'd17);
            step("rr3", 4'b1111, 1'b0, 1'b0, 4'b1000, 5'd0);
        end

        step("wrap_g2", 4'b0100, 1'b0, 1'b0, 4'b0100, 5'd17);
        step("wrap_a", 4'b0011, 1'b0, 1'b0, 4'b0001, 5'd3);
        step("wrap_b", 4'b0011, 1'b0, 1'b0, 4'b0010, 5'd9);
        step("wrap_c", 4'b0011, 1'b0, 1'b0, 4'b0001, 5'd3);

        for (int n = 0; n < 3; n++)
            step("busy", 4'b0010, 1'b1, 1'b0, 4'b0000, 5'd0);
        step("busy_rel", 4'b0010, 1'b0, 1'b0, 4'b0010, 5'd9);
        step("busy_ptr", 4'b1111, 1'b0, 1'b0, 4'b0100, 5'd17);

        step("midrst", 4'b0010, 1'b0, 1'b1, 4'b0000, 5'd0);
        step("midrst_rel", 4'b1010, 1'b0, 1'b0, 4'b0010, 5'd9);
        step("midrst_next", 4'b1010, 1'b0, 1'b0, 4'b1000, 5'd0);
        step("busy_and_rst", 4'b1111, 1'b1, 1'b1, 4'b0000, 5'd0);
        step("drain0", 4'b0000, 1'b0, 1'b0, 4'b0000, 5'd0);
        step("drain1", 4'b0000, 1'b0, 1'b0, 4'b0000, 5'd0);

        @(negedge clk);
        done = 1'b1;
        check("queue empty", 32'(exp_q.size()), 32'd0);
        check("returns seen", 32'(popped), 32'(pushed));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
